fifo_wptr_full: RTL and testbench
=================================

# fifo_wptr_full

Write-side pointer and status generator for the dual-clock FIFO. It is the producer of the Gray-coded write pointer that the read domain synchronizes. It consumes the read pointer after that pointer has been synchronized into the write clock domain. It maintains the binary/Gray write pointer, the memory write address and enable, full, almost-full, fill level and a sticky overflow flag, all in the write clock domain.

## Interface
- PTR_SZ, 2: address width; depth = 2^PTR_SZ; pointers are PTR_SZ+1 bits (extra wrap bit).
- AF_THRESH, 3: almost-full threshold in entries, 1..2^PTR_SZ.

- clk  input  1  write-domain clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- winc  input  1  write request from producer.
- wq2_rptr  input  PTR_SZ+1  read pointer, Gray-coded, already synchronized (two flops) into clk domain.
- wen  output  1  memory write enable = winc & ~wfull (combinational).
- waddr  output  PTR_SZ  memory write address = low PTR_SZ bits of binary write pointer.
- wptr  output  PTR_SZ+1  registered Gray write pointer, sent to read-domain synchronizer.
- wfull  output  1  registered full flag.
- walmost_full  output  1  registered, level >= AF_THRESH.
- wlevel  output  PTR_SZ+1  registered fill level, 0..2^PTR_SZ.
- wovf  output  1  sticky overflow: a write was attempted while full.

## Operation
- State: wbin (binary, PTR_SZ+1 bits), wptr (Gray), wfull, walmost_full, wlevel, wovf.
- wbin_next = wbin + wen, modulo 2^(PTR_SZ+1); wgray_next = (wbin_next >> 1) ^ wbin_next.
- rbin = Gray-to-binary of wq2_rptr (XOR prefix from MSB).
- level_next = (wbin_next - rbin) modulo 2^(PTR_SZ+1).
- Each edge: wbin <= wbin_next; wptr <= wgray_next; wlevel <= level_next; wfull <= (wgray_next == {~wq2_rptr[PTR_SZ:PTR_SZ-1], wq2_rptr[PTR_SZ-2:0]}); walmost_full <= (level_next >= AF_THRESH); wovf <= wovf | (winc & wfull).
- The Gray full compare and level_next == 2^PTR_SZ are equivalent. The implementation uses the Gray compare. The bench checks the equivalence.
- wptr changes by exactly one bit per accepted write. This includes the wrap from all-ones binary to 0.
- A write while full is dropped: wen=0, pointers hold, and wovf sets. wovf clears only on rst.
- Status is pessimistic. wq2_rptr lags the true read pointer, so full and level may overstate occupancy. They never understate it.

## Timing
- Reset: wbin, wptr, waddr, wlevel = 0; wfull, walmost_full, wovf = 0. rst dominates winc. wen = 0 while wfull = 0 only if winc = 0.
- Reset mid-operation: all state returns to reset values at the next edge, regardless of wq2_rptr. The read side is responsible for resetting its own pointer.
- Latency: an accepted write at edge n updates wptr, waddr, wlevel and flags at edge n.
- The write that fills the FIFO asserts wfull at the same edge as it lands. A winc in the following cycle is blocked.
- A wq2_rptr change in cycle n is reflected in wfull, wlevel and walmost_full at edge n, with 1 cycle of latency.
- Simultaneous write and read advance while not full: level is unchanged and wfull stays 0.
- Full and read advance in the same cycle: wen = 0 that cycle because wfull is registered. wfull deasserts at the edge.

## Test plan
Defaults: PTR_SZ=2, depth 4, AF_THRESH=3. Gray sequence is 0,1,3,2,6,7,5,4.
- Reset: assert rst 2 cycles with winc=1 and wq2_rptr=3. Required: wptr=0, waddr=0, wlevel=0, wfull=0, walmost_full=0, wovf=0.
- Fill: wq2_rptr=0, winc=1 for 4 cycles. Required: wptr steps 1,3,2,6; waddr steps 1,2,3,0; wlevel steps 1..4; walmost_full rises with wlevel=3; wfull rises with wptr=6.
- Overflow: while full, winc=1 for 2 cycles. Required: wen=0, wptr holds 6, wlevel holds 4, wovf=1 after the first edge and stays 1.
- Drain/refill: set wq2_rptr=1 (binary 1). Required: next edge wfull=0, wlevel=3, walmost_full=1. Then one write gives wptr=7 and wfull=1.
- Wrap: with wq2_rptr tracking the write pointer one entry behind, do 10 writes. Required: wptr cycles 0,1,3,2,6,7,5,4,0,... with a single-bit change per step, and wfull stays 0.
- Reset mid-operation: at wptr=5 and wovf=1, pulse rst 1 cycle. Required: all outputs return to 0 at that edge, and writes resume from waddr=0.

Source files
------------

// File: rtl/fifo_wptr_full.sv
// Write-domain pointer and status logic for the dual-clock FIFO: binary/Gray
// write pointer, memory write strobe, full/almost-full, fill level, sticky overflow.
module fifo_wptr_full #(
  parameter int unsigned PTR_SZ    = 2,
  parameter int unsigned AF_THRESH = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              winc,
  input  logic [PTR_SZ:0]   wq2_rptr,
  output logic              wen,
  output logic [PTR_SZ-1:0] waddr,
  output logic [PTR_SZ:0]   wptr,
  output logic              wfull,
  output logic              walmost_full,
  output logic [PTR_SZ:0]   wlevel,
  output logic              wovf
);

  // Full when the next write pointer equals the read pointer with its top two
  // Gray bits inverted (one lap ahead).
  localparam logic [PTR_SZ:0] FULL_MASK = (PTR_SZ+1)'(3) << (PTR_SZ - 1);
  localparam logic [PTR_SZ:0] AF_LVL    = (PTR_SZ+1)'(AF_THRESH);

  logic [PTR_SZ:0] wbin_q, wbin_d;
  logic [PTR_SZ:0] wptr_q, wptr_d;
  logic [PTR_SZ:0] wlevel_q, wlevel_d;
  logic            wfull_q, wfull_d;
  logic            walmost_full_q, walmost_full_d;
  logic            wovf_q, wovf_d;
  logic            wen_c;
  logic [PTR_SZ:0] rbin;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    rbin = '0;
    for (int unsigned i = 0; i <= PTR_SZ; i++) begin
      rbin[i] = ^(wq2_rptr >> i);
    end
  end

  always_comb begin
    wen_c          = winc & ~wfull_q;
    wbin_d         = wbin_q + {{PTR_SZ{1'b0}}, wen_c};
    wptr_d         = (wbin_d >> 1) ^ wbin_d;
    wlevel_d       = wbin_d - rbin;
    wfull_d        = (wptr_d == (wq2_rptr ^ FULL_MASK));
    walmost_full_d = (wlevel_d >= AF_LVL);
    wovf_d         = wovf_q | (winc & wfull_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wbin_q         <= '0;
      wptr_q         <= '0;
      wlevel_q       <= '0;
      wfull_q        <= 1'b0;
      walmost_full_q <= 1'b0;
      wovf_q         <= 1'b0;
    end else begin
      wbin_q         <= wbin_d;
      wptr_q         <= wptr_d;
      wlevel_q       <= wlevel_d;
      wfull_q        <= wfull_d;
      walmost_full_q <= walmost_full_d;
      wovf_q         <= wovf_d;
    end
  end

  assign wen          = wen_c;
  assign waddr        = wbin_q[PTR_SZ-1:0];
  assign wptr         = wptr_q;
  assign wfull        = wfull_q;
  assign walmost_full = walmost_full_q;
  assign wlevel       = wlevel_q;
  assign wovf         = wovf_q;

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Self-checking bench for fifo_wptr_full: directed scenarios with literal
// expectations plus randomized traffic against an occupancy-count model.
module tb_fifo_wptr_full;
  localparam int P     = 2;
  localparam int AF    = 3;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         winc = 1'b0;
  logic [P:0]   wq2_rptr = '0;
  logic         wen;
  logic [P-1:0] waddr;
  logic [P:0]   wptr;
  logic         wfull;
  logic         walmost_full;
  logic [P:0]   wlevel;
  logic         wovf;

  fifo_wptr_full #(.PTR_SZ(P), .AF_THRESH(AF)) dut (
    .clk(clk), .rst(rst), .winc(winc), .wq2_rptr(wq2_rptr),
    .wen(wen), .waddr(waddr), .wptr(wptr), .wfull(wfull),
    .walmost_full(walmost_full), .wlevel(wlevel), .wovf(wovf)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: absolute counts of accepted writes and consumed reads since reset.
  int w_abs = 0;
  int r_abs = 0;
  int m_level = 0;
  bit m_full = 0, m_af = 0, m_ovf = 0, m_acc = 0, m_rst = 0;
  bit chk_en = 0;
  logic [P:0] prev_wptr = '0;
  logic [P:0] gseq [8] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};

  function automatic logic [P:0] gray(input int n);
    logic [P:0] b;
    b = (P+1)'(n);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: drive inputs at the falling edge, advance the model for the
  // coming rising edge, then return shortly after that edge.
  task automatic step(input bit r, input bit w, input int rd);
    @(negedge clk);
    chk_en   = 1;
    rst      = r;
    winc     = w;
    wq2_rptr = gray(rd);
    m_rst    = r;
    if (r) begin
      w_abs = 0; r_abs = 0; m_level = 0;
      m_full = 0; m_af = 0; m_ovf = 0; m_acc = 0;
    end else begin
      m_acc = w && !m_full;
      m_ovf = m_ovf || (w && m_full);
      if (m_acc) w_abs++;
      r_abs   = rd;
      m_level = w_abs - r_abs;
      m_full  = (m_level == DEPTH);
      m_af    = (m_level >= AF);
    end
    @(posedge clk);
    #3;
  endtask

  always @(posedge clk) begin
    #2;
    if (chk_en) begin
      check("wptr",   wptr,   gray(w_abs));
      check("waddr",  waddr,  w_abs % DEPTH);
      check("wlevel", wlevel, m_level);
      check("wfull",  wfull,  m_full);
      check("walmost_full", walmost_full, m_af);
      check("wovf",   wovf,   m_ovf);
      if (!m_rst) check("wen", wen, winc && !m_full);
      if (!m_rst && m_acc) check("wptr_one_bit", $countones(wptr ^ prev_wptr), 1);
    end
    prev_wptr = wptr;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    logic [P:0]   fill_ptr [4];
    logic [P-1:0] fill_addr [4];
    bit           fill_af [4];
    bit           fill_full [4];
    bit r, w;
    int rd;
    fill_ptr  = '{3'd1, 3'd3, 3'd2, 3'd6};
    fill_addr = '{2'd1, 2'd2, 2'd3, 2'd0};
    fill_af   = '{1'b0, 1'b0, 1'b1, 1'b1};
    fill_full = '{1'b0, 1'b0, 1'b0, 1'b1};

    // Reset with write requested and a nonzero read pointer (Gray 3)
    step(1, 1, 2);
    step(1, 1, 2);
    check("rst_wptr", wptr, 0);
    check("rst_waddr", waddr, 0);
    check("rst_wlevel", wlevel, 0);
    check("rst_flags", {wfull, walmost_full, wovf}, 0);

    // Fill
    for (int k = 0; k < 4; k++) begin
      step(0, 1, 0);
      check("fill_wptr", wptr, fill_ptr[k]);
      check("fill_waddr", waddr, fill_addr[k]);
      check("fill_wlevel", wlevel, k + 1);
      check("fill_af", walmost_full, fill_af[k]);
      check("fill_full", wfull, fill_full[k]);
    end

    // Overflow
    for (int k = 0; k < 2; k++) begin
      step(0, 1, 0);
      check("ovf_wen", wen, 0);
      check("ovf_wptr", wptr, 6);
      check("ovf_wlevel", wlevel, 4);
      check("ovf_flag", wovf, 1);
    end

    // Drain one, refill one
    step(0, 0, 1);
    check("drain_full", wfull, 0);
    check("drain_wlevel", wlevel, 3);
    check("drain_af", walmost_full, 1);
    step(0, 1, 1);
    check("refill_wptr", wptr, 7);
    check("refill_full", wfull, 1);

    // Empty out, then wrap with the read pointer one entry behind
    step(0, 0, 5);
    check("empty_wlevel", wlevel, 0);
    for (int k = 0; k < 10; k++) begin
      step(0, 1, w_abs);
      check("wrap_wptr", wptr, gseq[(6 + k) % 8]);
      check("wrap_full", wfull, 0);
    end
    for (int k = 0; k < 8 && (w_abs % 8) != 6; k++) step(0, 1, w_abs);
    check("pre_rst_wptr", wptr, 5);
    check("pre_rst_ovf", wovf, 1);

    // Reset mid-operation
    step(1, 1, w_abs);
    check("mid_rst_outputs", {wptr, waddr, wlevel, wfull, walmost_full, wovf}, 0);
    step(0, 1, 0);
    check("resume_waddr", waddr, 1);
    check("resume_wptr", wptr, 1);

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      r  = ($urandom_range(0, 199) == 0);
      w  = ($urandom_range(0, 99) < 60);
      rd = r_abs;
      if (r_abs < w_abs && $urandom_range(0, 2) == 0) rd = r_abs + 1;
      step(r, w, rd);
    end

    @(posedge clk);
    #5;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
